// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo sequencer sharing one echo-measurement unit across NUM_SENS sensors.
// Optional feature macro: SONAR_SCHED_RETRY_EN (one silent retry per sensor before reporting a timeout).
module sonar_scheduler #(
  parameter int NUM_SENS    = 4,
  parameter int SEL_W       = 2,
  parameter int DIST_W      = 17,
  parameter int TRIG_CYC    = 500,
  parameter int ECHO_TO_CYC = 200000,
  parameter int GAP_CYC     = 2500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                meas_start,
  input  logic                meas_valid,
  input  logic [DIST_W-1:0]   meas_distance,
  output logic [NUM_SENS-1:0] sens_trigger,
  output logic [SEL_W-1:0]    echo_sel,
  output logic                res_valid,
  output logic                res_timeout,
  output logic [SEL_W-1:0]    res_id,
  output logic [DIST_W-1:0]   res_distance,
  output logic                busy
);

  localparam int PH_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(ECHO_TO_CYC + 1);

  localparam logic [PH_W-1:0]  TRIG_LAST = PH_W'(TRIG_CYC - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_CYC);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ECHO_TO_CYC);
  localparam logic [SEL_W-1:0] CUR_LAST  = SEL_W'(NUM_SENS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_MEAS,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]     tmr_q, tmr_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [NUM_SENS-1:0] trig_q, trig_d;
  logic                res_valid_q, res_valid_d;
  logic                res_timeout_q, res_timeout_d;
  logic [SEL_W-1:0]    res_id_q, res_id_d;
  logic [DIST_W-1:0]   res_dist_q, res_dist_d;
  logic                busy_q, busy_d;
  logic                to_hit;
`ifdef SONAR_SCHED_RETRY_EN
  logic                retry_q, retry_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    cur_d         = cur_q;
    res_valid_d   = 1'b0;
    res_timeout_d = 1'b0;
    res_id_d      = res_id_q;
    res_dist_d    = res_dist_q;
    to_hit        = 1'b0;
`ifdef SONAR_SCHED_RETRY_EN
    retry_d       = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_TRIG;
          cnt_d   = '0;
        end
      end
      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      ST_WAIT: begin
        if (tmr_q == TO_LAST) begin
          to_hit = 1'b1;
        end else begin
          tmr_d = tmr_q + TO_W'(1);
          if (meas_start) state_d = ST_MEAS;
        end
      end
      ST_MEAS: begin
        // A result landing on the terminal count wins over the timeout.
        if (meas_valid) begin
          state_d     = ST_GAP;
          cnt_d       = '0;
          res_valid_d = 1'b1;
          res_id_d    = cur_q;
          res_dist_d  = meas_distance;
`ifdef SONAR_SCHED_RETRY_EN
          retry_d     = 1'b0;
`endif
        end else if (tmr_q == TO_LAST) begin
          to_hit = 1'b1;
        end else begin
          tmr_d = tmr_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = enable ? ST_TRIG : ST_IDLE;
`ifdef SONAR_SCHED_RETRY_EN
          if (!retry_q)
            cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + SEL_W'(1);
`else
          cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + SEL_W'(1);
`endif
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_hit) begin
      state_d = ST_GAP;
      cnt_d   = '0;
`ifdef SONAR_SCHED_RETRY_EN
      // First silence re-fires the same sensor; the second is reported.
      if (retry_q) begin
        res_timeout_d = 1'b1;
        res_id_d      = cur_q;
        retry_d       = 1'b0;
      end else begin
        retry_d = 1'b1;
      end
`else
      res_timeout_d = 1'b1;
      res_id_d      = cur_q;
`endif
    end

    trig_d = '0;
    if (state_d == ST_TRIG) trig_d = NUM_SENS'(1) << cur_d;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmr_q         <= '0;
      cur_q         <= '0;
      trig_q        <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_id_q      <= '0;
      res_dist_q    <= '0;
      busy_q        <= 1'b0;
`ifdef SONAR_SCHED_RETRY_EN
      retry_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      cur_q         <= cur_d;
      trig_q        <= trig_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_id_q      <= res_id_d;
      res_dist_q    <= res_dist_d;
      busy_q        <= busy_d;
`ifdef SONAR_SCHED_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign sens_trigger = trig_q;
  assign echo_sel     = cur_q;
  assign res_valid    = res_valid_q;
  assign res_timeout  = res_timeout_q;
  assign res_id       = res_id_q;
  assign res_distance = res_dist_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with NUM_SENS=2, TRIG_CYC=5, ECHO_TO_CYC=50, GAP_CYC=20.
module tb_sonar_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        meas_start;
  logic        meas_valid;
  logic [16:0] meas_distance;
  logic [1:0]  sens_trigger;
  logic [1:0]  echo_sel;
  logic        res_valid;
  logic        res_timeout;
  logic [1:0]  res_id;
  logic [16:0] res_distance;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int n;

`ifdef SONAR_SCHED_RETRY_EN
  localparam int S1_TO_EXP = 128;
`else
  localparam int S1_TO_EXP = 51;
`endif

  sonar_scheduler #(
    .NUM_SENS(2), .SEL_W(2), .DIST_W(17),
    .TRIG_CYC(5), .ECHO_TO_CYC(50), .GAP_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .meas_start(meas_start), .meas_valid(meas_valid), .meas_distance(meas_distance),
    .sens_trigger(sens_trigger), .echo_sel(echo_sel),
    .res_valid(res_valid), .res_timeout(res_timeout),
    .res_id(res_id), .res_distance(res_distance), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] obs(input int which);
    case (which)
      0:       return {30'd0, sens_trigger};
      1:       return {31'd0, res_valid};
      2:       return {31'd0, res_timeout};
      3:       return {31'd0, busy};
      default: return 32'd0;
    endcase
  endfunction

  // Ticks until the selected output equals val; bounded so a stuck DUT shows as a count mismatch.
  task automatic wait_for(input int which, input logic [31:0] val, output int cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (obs(which) !== val && cnt < 300);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; meas_start = 1'b0; meas_valid = 1'b0; meas_distance = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_trig", sens_trigger, 0);
    chk("rst_echo_sel", echo_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_dist", res_distance, 0);

    // Sensor 0 trigger and a normal echo.
    enable = 1'b1;
    tick(1);
    chk("s0_trig_rise", sens_trigger, 2'b01);
    chk("s0_echo_sel", echo_sel, 0);
    chk("s0_busy", busy, 1);
    wait_for(0, 0, n);
    chk("s0_trig_width", n, 5);
    tick(2); meas_start = 1'b1;
    tick(1); meas_start = 1'b0;
    tick(6); meas_valid = 1'b1; meas_distance = 17'd1234;
    tick(1); meas_valid = 1'b0;
    chk("s0_res_valid", res_valid, 1);
    chk("s0_res_id", res_id, 0);
    chk("s0_res_dist", res_distance, 1234);
    chk("s0_no_timeout", res_timeout, 0);
    tick(1);
    chk("s0_valid_one_cycle", res_valid, 0);
    wait_for(0, 2'b10, n);
    chk("s1_trig_after_strobe", n + 1, 21);
    chk("s1_echo_sel", echo_sel, 1);

    // Sensor 1 silent: timeout.
    wait_for(0, 0, n);
    chk("s1_trig_width", n, 5);
    wait_for(2, 1, n);
    chk("s1_timeout_delay", n, S1_TO_EXP);
    chk("s1_timeout_id", res_id, 1);
    chk("s1_dist_held", res_distance, 1234);
    chk("s1_no_valid", res_valid, 0);
    wait_for(0, 2'b01, n);
    chk("wrap_to_s0", n, 21);
    chk("wrap_echo_sel", echo_sel, 0);

    // Sensor 0: meas_valid coincides with the timeout terminal count.
    wait_for(0, 0, n);
    meas_start = 1'b1;
    tick(1); meas_start = 1'b0;
    tick(49); meas_valid = 1'b1; meas_distance = 17'd777;
    tick(1); meas_valid = 1'b0;
    chk("tie_res_valid", res_valid, 1);
    chk("tie_res_timeout", res_timeout, 0);
    chk("tie_res_dist", res_distance, 777);
    tick(1);
    chk("tie_no_late_timeout", res_timeout, 0);
    wait_for(0, 2'b10, n);
    chk("tie_next_trig", n + 1, 21);

    // Sensor 1 quick result.
    wait_for(0, 0, n);
    meas_start = 1'b1;
    tick(1); meas_start = 1'b0;
    tick(2); meas_valid = 1'b1; meas_distance = 17'd42;
    tick(1); meas_valid = 1'b0;
    chk("s1b_res_id", res_id, 1);
    chk("s1b_res_dist", res_distance, 42);
    wait_for(0, 2'b01, n);
    chk("s1b_next_trig", n, 21);

    // Sensor 0 with enable dropped during MEAS.
    wait_for(0, 0, n);
    meas_start = 1'b1;
    tick(1); meas_start = 1'b0; enable = 1'b0;
    tick(3); meas_valid = 1'b1; meas_distance = 17'd999;
    tick(1); meas_valid = 1'b0;
    chk("dis_res_valid", res_valid, 1);
    chk("dis_res_id", res_id, 0);
    chk("dis_res_dist", res_distance, 999);
    chk("dis_busy_in_gap", busy, 1);
    wait_for(3, 0, n);
    chk("dis_gap_len", n, 21);
    chk("dis_idle_trig", sens_trigger, 0);
    chk("dis_idle_echo_sel", echo_sel, 1);
    tick(3);
    chk("dis_stays_idle", busy, 0);
    enable = 1'b1;
    tick(1);
    chk("resume_trig_s1", sens_trigger, 2'b10);
    chk("resume_echo_sel", echo_sel, 1);

    wait_for(0, 0, n);
    meas_start = 1'b1;
    tick(1); meas_start = 1'b0;
    tick(2); meas_valid = 1'b1; meas_distance = 17'd5;
    tick(1); meas_valid = 1'b0;
    wait_for(0, 2'b01, n);
    chk("pre_silent_trig_s0", n, 21);

    // Sensor 0 silent.
    wait_for(0, 0, n);
`ifdef SONAR_SCHED_RETRY_EN
    wait_for(0, 2'b01, n);
    chk("retry_retrigger_s0", n, 72);
    wait_for(0, 0, n);
`endif
    wait_for(2, 1, n);
    chk("s0_timeout_delay", n, 51);
    chk("s0_timeout_id", res_id, 0);
    wait_for(0, 2'b10, n);
    chk("s0_timeout_advance", n, 21);

    // Reset in the middle of WAIT.
    wait_for(0, 0, n);
    tick(10);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_trig", sens_trigger, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_echo_sel", echo_sel, 0);
    chk("mid_rst_res_id", res_id, 0);
    chk("mid_rst_res_dist", res_distance, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_timeout", res_timeout, 0);
    rst = 1'b0; enable = 1'b0;
    tick(3);
    chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
